// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned OVS_DEF = 16;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  // Expected parity bit: odd_sel=1 -> XOR of data, 0 -> XNOR (same rule as TX).
  function automatic logic rx_parity_bit(input logic [DATA_W-1:0] data, input logic odd_sel);
    return odd_sel ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for urxd_i: 2-flop synchronizer (idle-high reset),
// optionally followed by a 3-sample majority filter clocked by rx_bpsclk.
// Optional feature macro: UART_RX_GLITCH_FILTER_EN.
module uart_rx_sync (
  input  logic clk26m,
  input  logic rst26m_,
  input  logic rx_bpsclk,
  input  logic urxd_i,
  output logic line_s
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchronizer next-state
  always_comb begin
    sync1_d = urxd_i;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, reset to line idle level
  always_ff @(posedge clk26m or negedge rst26m_) begin
    if (!rst26m_) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [2:0] hist_q, hist_d;

  // Sample history advances only on oversampling ticks
  always_comb begin
    hist_d = hist_q;
    if (rx_bpsclk) hist_d = {hist_q[1:0], sync2_q};
  end

  // History flops, idle high
  always_ff @(posedge clk26m or negedge rst26m_) begin
    if (!rst26m_) hist_q <= 3'b111;
    else          hist_q <= hist_d;
  end

  assign line_s = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  logic unused_tick;
  assign unused_tick = rx_bpsclk;
  assign line_s      = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start/8 data/optional parity/stop framing with
// oversampled mid-bit sampling, holding register and valid/ready hand-off.
// Optional feature macro (in uart_rx_sync): UART_RX_GLITCH_FILTER_EN.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned OVS   = OVS_DEF,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk26m,
  input  logic              rst26m_,
  input  logic              rx_bpsclk,
  input  logic              urxd_i,
  input  logic              check,
  input  logic              parity,
  output logic              rx_bpsen,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              rx_busy
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVS - 1);

  logic line_s;

  rx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               chk_q, chk_d, par_q, par_d;
  logic               par_bad_q, par_bad_d, stop_bad_q, stop_bad_d;
  logic               deliver_q, deliver_d, brk_q, brk_d;
  logic               rx_bpsen_q, rx_bpsen_d, rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic               overrun_err_q, overrun_err_d, rx_busy_q, rx_busy_d;
  logic               mid_tick;

  uart_rx_sync u_sync (
    .clk26m    (clk26m),
    .rst26m_   (rst26m_),
    .rx_bpsclk (rx_bpsclk),
    .urxd_i    (urxd_i),
    .line_s    (line_s)
  );

  // Framing FSM, counters and hand-off logic
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    chk_d         = chk_q;
    par_d         = par_q;
    par_bad_d     = par_bad_q;
    stop_bad_d    = stop_bad_q;
    brk_d         = brk_q;
    deliver_d     = 1'b0;
    rx_data_d     = rx_data_q;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = 1'b0;
    rx_valid_d    = rx_valid_q & ~rx_ready;
    mid_tick      = rx_bpsclk && (tick_cnt_q == FULL_M1);

    // Bit-period tick counting; sampling states clear it themselves
    if (rx_bpsclk && state_q != ST_IDLE) tick_cnt_d = tick_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (brk_q) begin
          if (line_s) brk_d = 1'b0;
        end else if (!line_s) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          chk_d      = check;
          par_d      = parity;
          par_bad_d  = 1'b0;
        end
      end
      ST_START: begin
        if (rx_bpsclk && tick_cnt_q == HALF_M1) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = line_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (mid_tick) begin
          tick_cnt_d = '0;
          shift_d    = {line_s, shift_q[DATA_W-1:1]};
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) state_d = chk_q ? ST_CHECK : ST_STOP;
        end
      end
      ST_CHECK: begin
        if (mid_tick) begin
          tick_cnt_d = '0;
          par_bad_d  = (line_s != rx_parity_bit(shift_q, par_q));
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid_tick) begin
          tick_cnt_d = '0;
          stop_bad_d = ~line_s;
          brk_d      = ~line_s;
          deliver_d  = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Completed frame: load holding reg if it frees up this cycle, else drop
    if (deliver_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d   = 1'b1;
        rx_data_d    = shift_q;
        parity_err_d = par_bad_q;
        frame_err_d  = stop_bad_q;
      end else begin
        overrun_err_d = 1'b1;
      end
    end

    rx_bpsen_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    rx_busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk26m or negedge rst26m_) begin
    if (!rst26m_) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      chk_q         <= 1'b0;
      par_q         <= 1'b0;
      par_bad_q     <= 1'b0;
      stop_bad_q    <= 1'b0;
      deliver_q     <= 1'b0;
      brk_q         <= 1'b0;
      rx_bpsen_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      chk_q         <= chk_d;
      par_q         <= par_d;
      par_bad_q     <= par_bad_d;
      stop_bad_q    <= stop_bad_d;
      deliver_q     <= deliver_d;
      brk_q         <= brk_d;
      rx_bpsen_q    <= rx_bpsen_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      rx_busy_q     <= rx_busy_d;
    end
  end

  assign rx_bpsen    = rx_bpsen_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: directed scenarios plus randomized frames.
module tb_uart_rx_deser;

  localparam int TICK_DIV = 4;
  localparam int OVS      = 16;
  localparam int BIT_CLK  = TICK_DIV * OVS;

  logic       clk26m = 1'b0;
  logic       rst26m_ = 1'b0;
  logic       rx_bpsclk = 1'b0;
  logic       urxd_i = 1'b1;
  logic       check = 1'b0;
  logic       parity = 1'b0;
  logic       rx_bpsen;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  logic dir_ready = 1'b1;
  logic rand_ready = 1'b0;
  logic rnd_ready = 1'b1;
  assign rx_ready = rand_ready ? rnd_ready : dir_ready;

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  int xfer_cnt = 0;
  logic [9:0] exp_q[$];

  uart_rx_deser #(.OVS(16), .CNT_W(4)) dut (
    .clk26m      (clk26m),
    .rst26m_     (rst26m_),
    .rx_bpsclk   (rx_bpsclk),
    .urxd_i      (urxd_i),
    .check       (check),
    .parity      (parity),
    .rx_bpsen    (rx_bpsen),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk26m = ~clk26m;

  // Free-running oversampling tick, one clock in TICK_DIV
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk26m);
      #1;
      div = (div + 1) % TICK_DIV;
      rx_bpsclk = (div == 0);
    end
  end

  // Random backpressure source
  initial begin
    forever begin
      @(posedge clk26m);
      #1;
      rnd_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Reference parity bit from the count of ones
  function automatic logic ref_par(input logic [7:0] d, input logic odd_sel);
    int ones;
    ones = $countones(d);
    if (odd_sel) return ((ones % 2) == 1);
    return ((ones % 2) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int clks);
    urxd_i = b;
    repeat (clks) @(posedge clk26m);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic c, input logic p, input logic pbit,
                            input logic stopb, input logic scramble, input int tail_low);
    check  = c;
    parity = p;
    drive_bit(1'b1, 2);
    drive_bit(1'b0, BIT_CLK / 2);
    if (scramble) begin
      check  = ($urandom_range(0, 1) == 1);
      parity = ($urandom_range(0, 1) == 1);
    end
    drive_bit(1'b0, BIT_CLK - BIT_CLK / 2);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLK);
    if (c) drive_bit(pbit, BIT_CLK);
    drive_bit(stopb, BIT_CLK);
    if (tail_low > 0) drive_bit(1'b0, tail_low * BIT_CLK);
    urxd_i = 1'b1;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk26m);
      if (rx_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_busy) && n < 3000) begin
      @(negedge clk26m);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bpsen"},   32'(rx_bpsen), 32'd0);
    chk({tag, "_data"},    32'(rx_data), 32'd0);
    chk({tag, "_valid"},   32'(rx_valid), 32'd0);
    chk({tag, "_perr"},    32'(parity_err), 32'd0);
    chk({tag, "_ferr"},    32'(frame_err), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun_err), 32'd0);
    chk({tag, "_busy"},    32'(rx_busy), 32'd0);
  endtask

  initial begin
    logic ok;
    int ovr0, xfer0;
    logic [7:0] d;
    logic c, p, pgood, stopb, pb;

    // Monitor: pop and compare on every accepted transfer
    fork
      forever begin
        logic [9:0] e;
        @(negedge clk26m);
        if (rst26m_) begin
          if (overrun_err) ovr_cnt++;
          if (rx_valid && rx_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_xfer: got data 0x%0h perr %0b ferr %0b with nothing expected",
                       rx_data, parity_err, frame_err);
            end else begin
              e = exp_q.pop_front();
              chk("xfer", {22'd0, rx_data, parity_err, frame_err}, {22'd0, e});
            end
          end
        end
      end
    join_none

    repeat (5) @(negedge clk26m);
    chk_reset_outputs("rst");
    rst26m_ = 1'b1;
    repeat (10) @(posedge clk26m);
    #1;

    // Clean byte, 1-cycle valid with ready high
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      begin
        wait_valid(ok);
        chk("a5_valid_seen", 32'(ok), 32'd1);
        if (ok) begin
          @(negedge clk26m);
          chk("a5_valid_1cycle", 32'(rx_valid), 32'd0);
        end
      end
    join
    wait_drain("a5_drain");

    // Parity error: check=1 parity=1, wrong parity bit
    exp_q.push_back({8'h03, (1'b1 != ref_par(8'h03, 1'b1)), 1'b0});
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    drive_bit(1'b1, BIT_CLK);
    wait_drain("par_drain");

    // False start: 4-tick low pulse
    xfer0 = xfer_cnt;
    drive_bit(1'b0, 4 * TICK_DIV);
    drive_bit(1'b1, 2 * BIT_CLK);
    chk("false_busy", 32'(rx_busy), 32'd0);
    chk("false_bpsen", 32'(rx_bpsen), 32'd0);
    chk("false_noxfer", 32'(xfer_cnt - xfer0), 32'd0);

    // Overrun: ready low, second byte dropped
    dir_ready = 1'b0;
    ovr0 = ovr_cnt;
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    drive_bit(1'b1, BIT_CLK);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    drive_bit(1'b1, BIT_CLK);
    @(negedge clk26m);
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    chk("ovr_held_valid", 32'(rx_valid), 32'd1);
    chk("ovr_held_data", 32'(rx_data), 32'h11);
    @(posedge clk26m);
    #1;
    dir_ready = 1'b1;
    wait_drain("ovr_drain");
    chk("ovr_pulses_after", 32'(ovr_cnt - ovr0), 32'd1);

    // Framing error followed by a 3 bit-time break
    xfer0 = xfer_cnt;
    exp_q.push_back({8'h7E, 1'b0, 1'b1});
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    drive_bit(1'b1, 2 * BIT_CLK);
    wait_drain("brk_drain");
    chk("brk_single_frame", 32'(xfer_cnt - xfer0), 32'd1);

    // Reset mid-DATA aborts frame
    check = 1'b0;
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, BIT_CLK);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, BIT_CLK / 2);
    @(negedge clk26m);
    chk("data_busy", 32'(rx_busy), 32'd1);
    rst26m_ = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    urxd_i = 1'b1;
    repeat (4) @(posedge clk26m);
    #1;
    rst26m_ = 1'b1;
    drive_bit(1'b1, BIT_CLK);
    exp_q.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    drive_bit(1'b1, BIT_CLK);
    wait_drain("post_rst_drain");

    // Randomized frames with random backpressure and mid-frame config changes
    rand_ready = 1'b1;
    ovr0 = ovr_cnt;
    for (int n = 0; n < 20; n++) begin
      d     = 8'($urandom);
      c     = ($urandom_range(0, 1) == 1);
      p     = ($urandom_range(0, 1) == 1);
      pgood = ($urandom_range(0, 3) != 0);
      stopb = ($urandom_range(0, 4) != 0);
      pb    = pgood ? ref_par(d, p) : ~ref_par(d, p);
      exp_q.push_back({d, c & ~pgood, ~stopb});
      send_frame(d, c, p, pb, stopb, 1'b1, 0);
      drive_bit(1'b1, BIT_CLK / 2 + int'($urandom_range(0, BIT_CLK)));
    end
    wait_drain("rand_drain");
    chk("rand_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
    rand_ready = 1'b0;

    repeat (5) @(negedge clk26m);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
